// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   - FSM state encodings (IDLE, START, DATA, STOP, PARITY)
//   - default frame parameters
//   - line idle level
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_PARITY = 3'd4
    } uart_state_e;

    localparam int UART_DEF_OVERSAMPLING = 16;
    localparam int UART_DEF_DATA_BITS    = 8;
    localparam int UART_DEF_STOP_BITS    = 1;

    localparam logic UART_LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running cycle counter with a terminal-count strobe.
// Ports:
//   clk_in    - clock
//   rst       - asynchronous active-high reset
//   i_clear   - synchronous clear, wins over counting
//   i_target  - terminal count value
//   o_tc      - high while the count equals i_target
// The owner clears the timer on o_tc, so the count never wraps.
module uart_bit_timer #(
    parameter int W = 4
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         i_clear,
    input  logic [W-1:0] i_target,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst)          r_cnt <= '0;
        else if (i_clear) r_cnt <= '0;
        else              r_cnt <= r_cnt + 1'b1;
    end

    assign o_tc = (r_cnt == i_target);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: oversampled UART transmitter.
// Serialises one word per valid/ready handshake: start bit, LSB-first data,
// optional even parity, stop bit(s). Each bit lasts OVERSAMPLING clk_in cycles.
// Ports:
//   clk_in    - system clock
//   rst       - asynchronous active-high reset (abandons any frame, tx high)
//   valid_in  - data_in holds a word to send
//   data_in   - word to transmit, sampled on acceptance
//   ready_out - transmitter can accept a word (only in IDLE)
//   tx        - serial line, idle high
//   busy_out  - frame in progress
//   done_out  - one-cycle pulse at frame end
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data and stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = UART_DEF_DATA_BITS,
    parameter int STOP_BITS    = UART_DEF_STOP_BITS,
    parameter int OVERSAMPLING = UART_DEF_OVERSAMPLING
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 ready_out,
    output logic                 tx,
    output logic                 busy_out,
    output logic                 done_out
);

    localparam int CW = $clog2(OVERSAMPLING * STOP_BITS);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] T_BIT  = CW'(OVERSAMPLING - 1);
    localparam logic [CW-1:0] T_STOP = CW'(OVERSAMPLING * STOP_BITS - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    uart_state_e          r_state, w_state_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt, w_shift_sh;
    logic [BW-1:0]        r_bit, w_bit_nxt;
    logic                 r_tx, w_tx_nxt;
    logic                 r_ready, w_ready_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;
    logic                 w_tc, w_clear;
    logic [CW-1:0]        w_target;
`ifdef UART_TX_PARITY_EN
    logic                 r_par, w_par_nxt;
`endif

    // Timer runs only inside a frame; it restarts at every bit boundary.
    assign w_clear  = (r_state == ST_IDLE) || w_tc;
    assign w_target = (r_state == ST_STOP) ? T_STOP : T_BIT;

    uart_bit_timer #(.W(CW)) u_timer (
        .clk_in   (clk_in),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_target (w_target),
        .o_tc     (w_tc)
    );

    assign w_shift_sh = r_shift >> 1;

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_bit_nxt   = r_bit;
        w_tx_nxt    = r_tx;
        w_ready_nxt = r_ready;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            ST_IDLE: begin
                w_tx_nxt   = UART_LINE_IDLE;
                w_busy_nxt = 1'b0;
                if (valid_in && r_ready) begin
                    w_shift_nxt = data_in;
                    w_bit_nxt   = '0;
                    w_ready_nxt = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = ST_START;
`ifdef UART_TX_PARITY_EN
                    w_par_nxt   = ^data_in;
`endif
                end else begin
                    // Also raises ready on the first edge after reset.
                    w_ready_nxt = 1'b1;
                end
            end
            ST_START: begin
                if (w_tc) begin
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tc) begin
                    w_shift_nxt = w_shift_sh;
                    if (r_bit == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        w_tx_nxt    = r_par;
                        w_state_nxt = ST_PARITY;
`else
                        w_tx_nxt    = UART_LINE_IDLE;
                        w_state_nxt = ST_STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                        w_tx_nxt  = w_shift_sh[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tc) begin
                    w_tx_nxt    = UART_LINE_IDLE;
                    w_state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_tc) begin
                    w_state_nxt = ST_IDLE;
                    w_ready_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                // Illegal encoding: drop the frame and return to an idle line.
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = UART_LINE_IDLE;
                w_ready_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_bit   <= '0;
            r_tx    <= UART_LINE_IDLE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_bit   <= w_bit_nxt;
            r_tx    <= w_tx_nxt;
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
`ifdef UART_TX_PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end

    assign tx        = r_tx;
    assign ready_out = r_ready;
    assign busy_out  = r_busy;
    assign done_out  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx at default parameters.
// Define UART_TX_PARITY_EN for both bench and RTL to check the parity build.
module tb_uart_tx;

    localparam int OS = 16;
    localparam int DB = 8;
    localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
    localparam int NP = 1;
`else
    localparam int NP = 0;
`endif
    // Cycles from acceptance edge to the edge that ends the frame.
    localparam int FL = (1 + DB + NP + SB) * OS;

    logic          clk_in   = 1'b0;
    logic          rst      = 1'b0;
    logic          valid_in = 1'b0;
    logic [DB-1:0] data_in  = '0;
    logic          ready_out, tx, busy_out, done_out;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    uart_tx #(
        .DATA_BITS    (DB),
        .STOP_BITS    (SB),
        .OVERSAMPLING (OS)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_out (ready_out),
        .tx        (tx),
        .busy_out  (busy_out),
        .done_out  (done_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line level in cycle c after the accepting edge (c=1 is the
    // first cycle after it).
    function automatic logic exp_tx(input logic [DB-1:0] d, input int c);
        if (c <= OS)                return 1'b0;
        if (c <= (1 + DB) * OS)     return d[(c - OS - 1) / OS];
        if (c <= (1 + DB + NP) * OS) return ^d;
        return 1'b1;
    endfunction

    // Handshake one word at a negedge; returns just after the accepting edge.
    task automatic send(input logic [DB-1:0] d);
        @(negedge clk_in);
        check("ready before send", ready_out, 1);
        valid_in = 1'b1;
        data_in  = d;
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        data_in  = '0;
    endtask

    // Follow one frame from the accepting edge through the gap cycle.
    // inj != 0 pulses valid_in with a junk word during that cycle.
    task automatic watch(input string tag, input logic [DB-1:0] d, input int inj);
        int bad_tx = 0;
        int bad_hs = 0;
        int n_done = 0;
        for (int c = 1; c <= FL + 1; c++) begin
            @(negedge clk_in);
            if (tx !== exp_tx(d, c)) bad_tx++;
            if (c <= FL && (busy_out !== 1'b1 || ready_out !== 1'b0)) bad_hs++;
            if (done_out === 1'b1) n_done++;
            if (inj != 0 && c == inj)     begin valid_in = 1'b1; data_in = 8'h55; end
            if (inj != 0 && c == inj + 1) begin valid_in = 1'b0; data_in = '0;    end
        end
        check({tag, " tx bits"},      bad_tx, 0);
        check({tag, " busy/ready"},   bad_hs, 0);
        check({tag, " done count"},   n_done, 1);
        check({tag, " done at end"},  done_out, 1);
        check({tag, " ready at end"}, ready_out, 1);
        check({tag, " busy at end"},  busy_out, 0);
    endtask

    initial begin
        int bad;
        logic [DB-1:0] words [3];
        words[0] = 8'h3C; words[1] = 8'hC3; words[2] = 8'h01;

        // Reset state
        #2 rst = 1'b1;
        #1;
        check("rst tx", tx, 1);
        check("rst ready", ready_out, 0);
        check("rst busy", busy_out, 0);
        check("rst done", done_out, 0);
        valid_in = 1'b1;
        data_in  = 8'hEE;
        repeat (3) @(negedge clk_in);
        check("rst held ready", ready_out, 0);
        check("rst held tx", tx, 1);
        valid_in = 1'b0;
        rst = 1'b0;
        @(negedge clk_in);
        check("ready after release", ready_out, 1);

        // Single word
        send(8'hA5);
        watch("a5", 8'hA5, 0);
        @(negedge clk_in);
        check("a5 done clears", done_out, 0);
        check("a5 idle tx", tx, 1);

        // Back-to-back with valid held; data_in changes mid-frame
        @(negedge clk_in);
        valid_in = 1'b1;
        data_in  = 8'h00;
        @(posedge clk_in);
        #1 data_in = 8'hFF;
        watch("b2b 00", 8'h00, 0);
        @(posedge clk_in);
        #1;
        valid_in = 1'b0;
        data_in  = '0;
        watch("b2b ff", 8'hFF, 0);
        @(negedge clk_in);
        check("b2b done clears", done_out, 0);

        // valid_in pulse mid-frame is ignored
        send(8'h3C);
        watch("busy ign", 8'h3C, 40);
        bad = 0;
        repeat (40) begin
            @(negedge clk_in);
            if (tx !== 1'b1 || busy_out !== 1'b0) bad++;
        end
        check("no junk frame", bad, 0);

        // Reset mid-frame
        send(8'hF0);
        repeat (69) @(negedge clk_in);
        check("pre-reset tx", tx, 0);
        #2 rst = 1'b1;
        #1;
        check("mid rst tx", tx, 1);
        check("mid rst ready", ready_out, 0);
        check("mid rst busy", busy_out, 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk_in);
            if (done_out !== 1'b0 || ready_out !== 1'b0 || tx !== 1'b1) bad++;
        end
        check("during rst", bad, 0);
        rst = 1'b0;
        bad = 0;
        repeat (FL) begin
            @(negedge clk_in);
            if (done_out !== 1'b0 || tx !== 1'b1) bad++;
        end
        check("no done after abort", bad, 0);
        send(8'h81);
        watch("post rst 81", 8'h81, 0);

        // Word sequence as used for loopback
        for (int i = 0; i < 3; i++) begin
            send(words[i]);
            watch($sformatf("word%0d", i), words[i], 0);
        end

`ifdef UART_TX_PARITY_EN
        send(8'hA4);
        watch("par a4", 8'hA4, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
